// File: rtl/fpu_store_buffer.sv
// fpu_store_buffer: in-order store buffer between the FPU and the data-memory
// write port. Stores are queued in a small circular buffer, drained one per
// cycle whenever the integer pipeline leaves the port free, and forwarded to
// younger loads of the same word.
module fpu_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    input  logic                       mem_busy,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_hit,
    output logic [DW-1:0]              ld_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage; contents are only meaningful inside the rp..wp window,
    // so the arrays carry no reset.
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] wp_reg;
    logic [PW-1:0] rp_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;

    logic          push;
    logic          pop;

    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] entry_match;
    logic [PW-1:0]    entry_age [DEPTH];

    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] fwd_idx;

    // Byte offset of the load address never takes part in matching.
    logic          ld_offset_unused;
    assign ld_offset_unused = ^ld_addr[1:0];

    // Full means refuse, even if a pop frees a slot this same cycle.
    assign st_ready = (count_reg < CW'(DEPTH));
    assign push     = st_valid && st_ready;
    assign pop      = (count_reg != '0) && !mem_busy;

    // Per-entry occupancy (distance from the head below count) and word match.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_age[gi]   = PW'(gi) - rp_reg;
            assign entry_valid[gi] = ({1'b0, entry_age[gi]} < count_reg);
            assign entry_match[gi] = entry_valid[gi] &&
                                     (addr_mem[gi][AW-1:2] == ld_addr[AW-1:2]);
        end
    endgenerate

    // Forwarding: in-flight register first, then walk entries oldest to
    // youngest so the youngest matching store overrides everything else.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (mem_we_reg && (mem_addr_reg[AW-1:2] == ld_addr[AW-1:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = mem_wdata_reg;
        end
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rp_reg + PW'(k);
            if (entry_match[fwd_idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[fwd_idx];
            end
        end
    end

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Entry write at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wp_reg] <= st_addr;
            data_mem[wp_reg] <= st_data;
        end
    end

    // Pointers, occupancy and the registered memory write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_reg        <= '0;
            rp_reg        <= '0;
            count_reg     <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wp_reg <= wp_reg + PW'(1);
            end
            if (pop) begin
                rp_reg        <= rp_reg + PW'(1);
                mem_we_reg    <= 1'b1;
                mem_addr_reg  <= addr_mem[rp_reg];
                mem_wdata_reg <= data_mem[rp_reg];
            end else begin
                mem_we_reg    <= 1'b0;
            end
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign count     = count_reg;
    assign empty     = (count_reg == '0) && !mem_we_reg;
    assign ld_hit    = fwd_hit;
    assign ld_data   = fwd_data;

endmodule
